// File: rtl/maze_scan.sv
// maze_scan: row-scanned 8x8 two-colour maze display and player engine.
// One ROM port serves both the display scan and the collision lookup.
module maze_scan #(
  parameter int SCAN_DIV = 5000,
  parameter int START_X  = 1,
  parameter int START_Y  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] map_addr,
  input  logic [7:0] map_data,
  output logic [7:0] row_n,
  output logic [7:0] col_green,
  output logic [7:0] col_red,
  output logic       coll,
  output logic       win
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [2:0] SX = 3'(START_X);
  localparam logic [2:0] SY = 3'(START_Y);

  typedef enum logic {IDLE, PEND} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    px_q, px_d;
  logic [2:0]    py_q, py_d;
  logic [2:0]    tx_q, tx_d;
  logic [2:0]    ty_q, ty_d;
  logic          coll_q, coll_d;
  logic          win_q, win_d;
  logic [3:0]    sync1_q, sync2_q, prev_q;
  logic [3:0]    btn_raw, btn_edge;
  logic [7:0]    row_n_q, green_q, red_q, red_d;

  // bit order: 0 up, 1 down, 2 left, 3 right
  assign btn_raw  = {btn_right, btn_left, btn_down, btn_up};
  assign btn_edge = sync2_q & ~prev_q;

  assign map_addr  = {coll_q, idx_q};
  assign row_n     = row_n_q;
  assign col_green = green_q;
  assign col_red   = red_q;
  assign coll      = coll_q;
  assign win       = win_q;

  always_comb begin
    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  always_comb begin
    red_d = 8'h00;
    if (idx_q == py_q && !coll_q) begin
      red_d = 8'b1 << px_q;
    end
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    coll_d  = coll_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (!coll_q && !win_q) begin
          priority case (1'b1)
            btn_edge[0]: begin
              if (py_q != 3'd0) begin
                tx_d    = px_q;
                ty_d    = py_q - 3'd1;
                state_d = PEND;
              end
            end
            btn_edge[1]: begin
              if (py_q == 3'd7) begin
                win_d = 1'b1;
              end else begin
                tx_d    = px_q;
                ty_d    = py_q + 3'd1;
                state_d = PEND;
              end
            end
            btn_edge[2]: begin
              if (px_q != 3'd0) begin
                tx_d    = px_q - 3'd1;
                ty_d    = py_q;
                state_d = PEND;
              end
            end
            btn_edge[3]: begin
              if (px_q != 3'd7) begin
                tx_d    = px_q + 3'd1;
                ty_d    = py_q;
                state_d = PEND;
              end
            end
            default: ;
          endcase
        end
      end
      PEND: begin
        // coll is 0 here, so map_data is the maze row idx_q
        if (idx_q == ty_q) begin
          if (map_data[tx_q]) begin
            coll_d = 1'b1;
          end else begin
            px_d = tx_q;
            py_d = ty_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= 3'd0;
      px_q    <= SX;
      py_q    <= SY;
      tx_q    <= 3'd0;
      ty_q    <= 3'd0;
      coll_q  <= 1'b0;
      win_q   <= 1'b0;
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      prev_q  <= 4'd0;
      row_n_q <= 8'hFF;
      green_q <= 8'h00;
      red_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      coll_q  <= coll_d;
      win_q   <= win_d;
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      row_n_q <= ~(8'b1 << idx_q);
      green_q <= map_data;
      red_q   <= red_d;
    end
  end

endmodule
